// File: rtl/centroid_sample_reader.sv
// centroid_sample_reader
//   Reads N interleaved (X, Y) sample words back out of Block RAM port B and
//   presents them one at a time to the k-means core.
//   Sample k lives at BASE_ADDR+2k (X) and BASE_ADDR+2k+1 (Y), modulo 2^ADDR_W.
//
// Ports
//   Reader_clk    system clock, also the RAM port B clock
//   Reader_rst    asynchronous active-low reset
//   start         command pulse, only looked at in IDLE
//   num_samples   sample count N, latched when start is accepted
//   ADDRB/ENB     registered RAM read address / read enable
//   DOUTB         RAM read data, valid RD_LAT edges after the read edge
//   SampleX/SampleY/SampleIdx  current sample and its index k
//   sample_valid/sample_ready  output handshake
//   busy          a read sequence is in progress
//   done          one-cycle pulse when the sequence completes
//   dbg_state     current FSM state, for observation only
//
// Handshake: sample_valid rises only with a complete (X, Y, k) sample and
// stays high, with the sample held stable, until an edge that sees
// sample_valid & sample_ready. That edge is the transfer. sample_ready is
// ignored while sample_valid is low.
module centroid_sample_reader #(
  parameter int unsigned        ADDR_W    = 19,
  parameter int unsigned        DATA_W    = 12,
  parameter int unsigned        CNT_W     = 7,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        RD_LAT    = 1    // legal range 1..3
) (
  input  logic              Reader_clk,
  input  logic              Reader_rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  output logic [ADDR_W-1:0] ADDRB,
  output logic              ENB,
  input  logic [DATA_W-1:0] DOUTB,
  output logic [DATA_W-1:0] SampleX,
  output logic [DATA_W-1:0] SampleY,
  output logic [CNT_W-1:0]  SampleIdx,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_X = 3'd1,
    ISSUE_Y = 3'd2,
    WAIT    = 3'd3,
    PRESENT = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   n_lat;
  logic [CNT_W-1:0]   k;
  logic               zero_pend;   // N=0 accepted; done goes out on the following edge
  logic               rd_tag;      // travels with ENB: 0 = X word, 1 = Y word
  logic [RD_LAT-1:0]  pipe_v;
  logic [RD_LAT-1:0]  pipe_t;

  logic [CNT_W-1:0]   k_next;
  logic [ADDR_W-1:0]  addr_x;
  logic [ADDR_W-1:0]  addr_x_next;
  logic               cap_v;
  logic               cap_y;
  logic               last_sample;

  assign k_next      = k + CNT_W'(1);
  assign addr_x      = BASE_ADDR + (ADDR_W'(k) << 1);
  assign addr_x_next = BASE_ADDR + (ADDR_W'(k_next) << 1);
  // The oldest pipeline stage lines up with the edge on which DOUTB holds its word.
  assign cap_v       = pipe_v[RD_LAT-1];
  assign cap_y       = pipe_t[RD_LAT-1];
  assign last_sample = (k == n_lat - CNT_W'(1));
  assign dbg_state   = state;

  always_ff @(posedge Reader_clk or negedge Reader_rst) begin
    if (!Reader_rst) begin
      state        <= IDLE;
      n_lat        <= '0;
      k            <= '0;
      zero_pend    <= 1'b0;
      rd_tag       <= 1'b0;
      pipe_v       <= '0;
      pipe_t       <= '0;
      ADDRB        <= '0;
      ENB          <= 1'b0;
      SampleX      <= '0;
      SampleY      <= '0;
      SampleIdx    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      ENB  <= 1'b0;
      done <= 1'b0;

      // Tag pipeline: records, per edge, whether a read was presented and which word.
      pipe_v <= (pipe_v << 1) | RD_LAT'(ENB);
      pipe_t <= (pipe_t << 1) | RD_LAT'(rd_tag);

      // Returned words only arrive before sample_valid rises, so this never
      // disturbs a presented sample.
      if (cap_v) begin
        if (cap_y) SampleY <= DOUTB;
        else       SampleX <= DOUTB;
      end

      case (state)
        IDLE: begin
          if (zero_pend) begin
            zero_pend <= 1'b0;
            done      <= 1'b1;
          end else if (start) begin
            n_lat <= num_samples;
            k     <= '0;
            if (num_samples == '0) begin
              zero_pend <= 1'b1;
            end else begin
              busy   <= 1'b1;
              ENB    <= 1'b1;
              ADDRB  <= BASE_ADDR;
              rd_tag <= 1'b0;
              state  <= ISSUE_X;
            end
          end
        end

        ISSUE_X: begin
          // X read is on the port this cycle; set up the Y read for the next one.
          ENB    <= 1'b1;
          ADDRB  <= addr_x + ADDR_W'(1);
          rd_tag <= 1'b1;
          state  <= ISSUE_Y;
        end

        ISSUE_Y: begin
          state <= WAIT;
        end

        WAIT: begin
          if (cap_v && cap_y) begin
            sample_valid <= 1'b1;
            SampleIdx    <= k;
            state        <= PRESENT;
          end
        end

        PRESENT: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            if (last_sample) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              k      <= k_next;
              ENB    <= 1'b1;
              ADDRB  <= addr_x_next;
              rd_tag <= 1'b0;
              state  <= ISSUE_X;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_sample_reader.sv
// Bench for centroid_sample_reader. Three instances share clock and reset:
//   u0: RD_LAT=1, BASE_ADDR=0
//   u1: RD_LAT=3, BASE_ADDR=0
//   u2: RD_LAT=1, BASE_ADDR=2^19-2 (address wrap)
// Only one instance is active per scenario; the negedge monitor watches it.
module tb_centroid_sample_reader;

  localparam int AW = 19;
  localparam int DW = 12;
  localparam int CW = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [2:0]    start_v;
  logic [CW-1:0] num;
  logic          rdy;
  logic [AW-1:0] addrb [3];
  logic          enb   [3];
  logic [DW-1:0] doutb [3];
  logic [DW-1:0] sx    [3];
  logic [DW-1:0] sy    [3];
  logic [CW-1:0] sidx  [3];
  logic          sv    [3];
  logic          busy  [3];
  logic          done  [3];
  logic [2:0]    dbg   [3];

  centroid_sample_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
    .BASE_ADDR(19'h00000), .RD_LAT(1)) u0 (
    .Reader_clk(clk), .Reader_rst(rst_n), .start(start_v[0]), .num_samples(num),
    .ADDRB(addrb[0]), .ENB(enb[0]), .DOUTB(doutb[0]), .SampleX(sx[0]), .SampleY(sy[0]),
    .SampleIdx(sidx[0]), .sample_valid(sv[0]), .sample_ready(rdy), .busy(busy[0]),
    .done(done[0]), .dbg_state(dbg[0]));

  centroid_sample_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
    .BASE_ADDR(19'h00000), .RD_LAT(3)) u1 (
    .Reader_clk(clk), .Reader_rst(rst_n), .start(start_v[1]), .num_samples(num),
    .ADDRB(addrb[1]), .ENB(enb[1]), .DOUTB(doutb[1]), .SampleX(sx[1]), .SampleY(sy[1]),
    .SampleIdx(sidx[1]), .sample_valid(sv[1]), .sample_ready(rdy), .busy(busy[1]),
    .done(done[1]), .dbg_state(dbg[1]));

  centroid_sample_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
    .BASE_ADDR(19'h7FFFE), .RD_LAT(1)) u2 (
    .Reader_clk(clk), .Reader_rst(rst_n), .start(start_v[2]), .num_samples(num),
    .ADDRB(addrb[2]), .ENB(enb[2]), .DOUTB(doutb[2]), .SampleX(sx[2]), .SampleY(sy[2]),
    .SampleIdx(sidx[2]), .sample_valid(sv[2]), .sample_ready(rdy), .busy(busy[2]),
    .done(done[2]), .dbg_state(dbg[2]));

  function automatic int lat_of(int a);
    return (a == 1) ? 3 : 1;
  endfunction

  function automatic logic [AW-1:0] base_of(int a);
    return (a == 2) ? 19'h7FFFE : 19'h00000;
  endfunction

  // ---------------- RAM model (1K words, address mirrored) ----------------
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rq [3][3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (enb[i]) rq[i][0] <= mem[addrb[i][9:0]];
      rq[i][1] <= rq[i][0];
      rq[i][2] <= rq[i][1];
    end
  end
  assign doutb[0] = rq[0][0];
  assign doutb[1] = rq[1][2];
  assign doutb[2] = rq[2][0];

  // ---------------- scoreboard ----------------
  logic [30:0]   exp_q[$];   // {idx, X, Y}
  logic [AW-1:0] addr_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int act = 0;
  int start_edge, last_rise, last_xfer_edge, done_edge;
  int xfer_cnt, done_cnt, enb_cnt;
  bit first_pend = 1'b0;
  bit chk_period = 1'b0;
  bit prev_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (enb[act]) begin
        enb_cnt++;
        if (addr_q.size() == 0) check("enb_extra", 64'(enb[act]), 64'd0);
        else check("addrb", 64'(addrb[act]), 64'(addr_q.pop_front()));
      end
      if (sv[act] && !prev_v) begin
        if (first_pend) begin
          check("first_lat", 64'(cyc - start_edge), 64'(2 + lat_of(act)));
          first_pend = 1'b0;
        end else if (chk_period) begin
          check("period", 64'(cyc - last_rise), 64'(3 + lat_of(act)));
        end
        last_rise = cyc;
      end
      if (sv[act] && rdy) begin
        xfer_cnt++;
        last_xfer_edge = cyc + 1;
        if (exp_q.size() == 0) check("xfer_extra", 64'(sv[act]), 64'd0);
        else check("sample", 64'({sidx[act], sx[act], sy[act]}), 64'(exp_q.pop_front()));
      end
      if (done[act]) begin
        done_cnt++;
        done_edge = cyc;
      end
      prev_v = sv[act];
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic rand_mem();
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
  endtask

  task automatic start_run(input int a, input int n);
    logic [AW-1:0] ax, ay;
    for (int k = 0; k < n; k++) begin
      ax = base_of(a) + AW'(2 * k);
      ay = ax + AW'(1);
      addr_q.push_back(ax);
      addr_q.push_back(ay);
      exp_q.push_back({CW'(k), mem[ax[9:0]], mem[ay[9:0]]});
    end
    act        = a;
    xfer_cnt   = 0;
    done_cnt   = 0;
    enb_cnt    = 0;
    first_pend = (n > 0);
    num        = CW'(n);
    start_v[a] = 1'b1;
    @(posedge clk); #1;
    start_v[a] = 1'b0;
    start_edge = cyc;
  endtask

  task automatic wait_done(input int budget, input bit rand_rdy);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    end
    if (done_cnt == 0) check("done_timeout", 64'(done_cnt), 64'd1);
    rdy = 1'b1;
  endtask

  task automatic end_checks(input int n);
    check("xfers", 64'(xfer_cnt), 64'(n));
    check("dones", 64'(done_cnt), 64'd1);
    check("addr_left", 64'(addr_q.size()), 64'd0);
    check("exp_left", 64'(exp_q.size()), 64'd0);
    check("enb_cycles", 64'(enb_cnt), 64'(2 * n));
    if (n > 0) check("done_at_xfer", 64'(done_edge), 64'(last_xfer_edge));
    addr_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle(input int a);
    check("idle_outputs", 64'({addrb[a], enb[a], sx[a], sy[a], sidx[a], sv[a], busy[a], done[a]}), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start_v = '0;
    num     = '0;
    rdy     = 1'b0;
    rst_n   = 1'b0;
    rand_mem();

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    for (int a = 0; a < 3; a++) check_idle(a);
    rst_n = 1'b1;
    enb_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_enb", 64'(enb_cnt), 64'd0);
    for (int a = 0; a < 3; a++) check_idle(a);

    // Basic read with fixed contents
    mem[0] = 12'h123; mem[1] = 12'h456; mem[2] = 12'h7A9; mem[3] = 12'h00F;
    chk_period = 1'b1;
    rdy = 1'b1;
    start_run(0, 2);
    wait_done(100, 1'b0);
    end_checks(2);

    // Backpressure
    rand_mem();
    chk_period = 1'b0;
    rdy = 1'b0;
    start_run(0, 3);
    for (int i = 0; i < 50 && !sv[0]; i++) begin @(posedge clk); #1; end
    check("bp_valid_rise", 64'(sv[0]), 64'd1);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_hold", 64'({sv[0], sidx[0], sx[0], sy[0]}), 64'({1'b1, exp_q[0]}));
      check("bp_enb", 64'(enb[0]), 64'd0);
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    check("bp_one_xfer", 64'(xfer_cnt), 64'd1);
    check("bp_valid_drop", 64'(sv[0]), 64'd0);
    rdy = 1'b1;
    wait_done(200, 1'b0);
    end_checks(3);

    // Zero count
    start_run(0, 0);
    check("zero_busy", 64'(busy[0]), 64'd0);
    wait_done(10, 1'b0);
    check("zero_done_lat", 64'(done_edge - start_edge), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    end_checks(0);

    // Start ignored while busy
    rand_mem();
    chk_period = 1'b1;
    start_run(0, 3);
    repeat (4) @(posedge clk);
    #1;
    num = CW'(5);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(200, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    end_checks(3);

    // Longer read latency
    rand_mem();
    start_run(1, 4);
    wait_done(300, 1'b0);
    end_checks(4);

    // Mid-run reset during WAIT of the third sample
    rand_mem();
    start_run(0, 5);
    for (int i = 0; i < 100 && xfer_cnt < 2; i++) begin @(posedge clk); #1; end
    check("mid_reach", 64'(xfer_cnt), 64'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    addr_q.delete();
    exp_q.delete();
    done_cnt = 0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_cnt), 64'd0);
    check("rst_quiet", 64'({sv[0], busy[0]}), 64'd0);
    start_run(0, 1);
    wait_done(100, 1'b0);
    end_checks(1);

    // Address wrap at the top of the space
    rand_mem();
    start_run(2, 2);
    wait_done(100, 1'b0);
    end_checks(2);

    // Randomized runs with random ready
    chk_period = 1'b0;
    for (int r = 0; r < 6; r++) begin
      int a, n;
      a = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 6));
      rand_mem();
      start_run(a, n);
      wait_done(500, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      end_checks(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/centroid_sample_reader.md
Name: centroid_sample_reader

Overview:
- Read-side counterpart of the random-sample generator.
- The generator writes N samples into Block RAM as interleaved 12-bit words: X at even offsets, Y at odd offsets.
- This block takes a start command and reads those words back through the RAM read port (port B), pairing X and Y.
- It delivers each (X, Y, index) sample to the k-means core over a valid/ready handshake.

Parameters:
- ADDR_W, 19, Block RAM address width.
- DATA_W, 12, RAM word width and SampleX/SampleY width.
- CNT_W, 7, width of the sample count and index.
- BASE_ADDR, 0, RAM address of sample 0's X word.
- RD_LAT, 1, RAM read latency in clock edges; legal range 1..3.

Ports:
- Reader_clk  in  1  system clock; also drives the RAM port B clock.
- Reader_rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- num_samples  in  CNT_W  number of samples to read; latched when start is accepted.
- ADDRB  out  ADDR_W  RAM read address (registered).
- ENB  out  1  RAM read enable (registered).
- DOUTB  in  DATA_W  RAM read data.
- SampleX  out  DATA_W  X of the current sample.
- SampleY  out  DATA_W  Y of the current sample.
- SampleIdx  out  CNT_W  index k of the current sample, 0..N-1.
- sample_valid  out  1  a sample is presented.
- sample_ready  in  1  consumer accepts the sample.
- busy  out  1  a read sequence is in progress.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (asynchronous, Reader_rst low):
  - All outputs go to 0; state goes to IDLE; internal counters and the latency pipeline are cleared.
  - Asserting reset mid-sequence aborts it. No done pulse is produced, and any in-flight RAM data is discarded.
- States: IDLE, ISSUE_X, ISSUE_Y, WAIT, PRESENT.
- IDLE:
  - start=1 latches N=num_samples and sets k=0 and busy=1.
  - If N=0: busy stays 0, done pulses on the next edge, state stays IDLE, ENB never asserts.
  - If N>0: go to ISSUE_X.
- ISSUE_X: for one cycle, ENB=1 and ADDRB=BASE_ADDR+2k. Then go to ISSUE_Y.
- ISSUE_Y: for one cycle, ENB=1 and ADDRB=BASE_ADDR+2k+1. Then go to WAIT. ENB is 0 in every other state.
- Capture timing:
  - A read presented at edge E (the edge at which the RAM samples ENB=1) returns data that is captured at edge E+RD_LAT.
  - An RD_LAT-deep tag pipeline steers the first returned word to SampleX and the second to SampleY.
- WAIT: on the edge that captures Y, set sample_valid=1 and SampleIdx=k, then go to PRESENT.
- PRESENT:
  - SampleX, SampleY and SampleIdx hold stable while sample_valid=1.
  - An edge with sample_valid&sample_ready is a transfer.
  - On a transfer with k<N-1: clear sample_valid, increment k, go to ISSUE_X. ENB is high in the cycle after the transfer edge.
  - On a transfer with k=N-1: clear sample_valid and busy, pulse done for one cycle, go to IDLE.
  - sample_ready while sample_valid=0 is ignored.
- Latency:
  - From the start-accept edge to sample_valid high is 2+RD_LAT edges.
  - From a transfer edge to the next sample_valid high is 2+RD_LAT edges.
  - With sample_ready held high, the throughput is one sample per 3+RD_LAT cycles.
- start while busy=1 is ignored, and num_samples is not re-latched.
- Address arithmetic is modulo 2^ADDR_W; BASE_ADDR+2k+1 wrapping past the top of the space is legal.
- Each sample is issued exactly two reads; no prefetch, no re-reads.
- The k counter is CNT_W wide; N=127 is the maximum count.

Test Plan:
- Reset then idle, with RD_LAT=1:
  - Stimulus: hold Reader_rst low, then release.
  - Required: all outputs are 0; ENB stays 0 for 20 cycles without start.
- Basic read, with RAM preloaded X0=0x123, Y0=0x456, X1=0x7A9, Y1=0x00F and BASE_ADDR=0:
  - Stimulus: start with num_samples=2 and sample_ready held 1.
  - Required: ADDRB sequence 0,1,2,3 with ENB high for exactly 2 cycles per sample.
  - Required: samples (0x123,0x456,idx 0) then (0x7A9,0x00F,idx 1).
  - Required: first valid 3 edges after start; sample period 4 cycles; done pulses at the transfer edge of idx 1.
- Backpressure:
  - Stimulus: sample_ready held 0 for 10 cycles after valid rises.
  - Required: SampleX, SampleY, SampleIdx and valid stay stable; no ENB activity; on ready=1 exactly one transfer occurs.
- Zero count and ignored start:
  - Stimulus: start with num_samples=0.
  - Required: done pulses 1 edge later; ENB is never asserted.
  - Stimulus: pulse start with num_samples=5 during a 3-sample run.
  - Required: exactly 3 samples are delivered.
- Latency parameter:
  - Stimulus: RD_LAT=3, N=4, sample_ready held 1.
  - Required: valid rises 5 edges after start; period 6 cycles; X/Y pairing is correct.
- Mid-run reset and wrap:
  - Stimulus: assert reset during WAIT of sample 2 of 5.
  - Required: outputs clear immediately; no done; a new start with N=1 reads correctly.
  - Stimulus: BASE_ADDR=2^19-2, N=2.
  - Required: ADDRB sequence 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
